face_detect_mac_pipe: RTL and testbench
=======================================

# face_detect_mac_pipe

Parametrised, fully pipelined signed multiply(-accumulate) unit with a valid/ready handshake on both sides. It generalises the fixed-width 4-stage DSP multiplier used in the face-detection accelerator. Operand widths, product width and pipeline depth are configurable, and the output saturates instead of truncating. An optional accumulate mode sums a group of products. It sits between the integral-image/feature-fetch stage and the classifier threshold compare. It absorbs back-pressure, so upstream no longer needs to gate `ce` by hand.

## Interface

Parameters:
- `A_W`, 13: width of signed operand A.
- `B_W`, 20: width of signed operand B.
- `P_W`, 32: width of signed result; `P_W` ≤ `ACC_W`.
- `NUM_STAGE`, 4: multiply pipeline depth, ≥ 2.
- `ACC_W`, 48: accumulator width. Used only with accumulate mode; `ACC_W` ≥ `A_W+B_W`.

Ports:
- `clk` input 1: single clock; all state is updated on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand beat valid.
- `in_ready` output 1: unit can accept a beat.
- `in_a` input `A_W`: signed operand A.
- `in_b` input `B_W`: signed operand B.
- `in_first` input 1: beat starts a new accumulation group (accumulate mode only).
- `in_last` input 1: beat ends the group (accumulate mode only).
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_p` output `P_W`: signed, saturated result.
- `out_sat` output 1: saturation occurred for this result.

## Operation

- Accept a beat when `in_valid && in_ready`.
- Global advance enable: `adv = !out_valid || out_ready`. Then `in_ready = adv`, a combinational function of registered `out_valid` and `out_ready`.
- When `adv` = 0, every stage, including its valid bit, holds.
- Bubbles are not collapsed.
- Stage 1 registers `a`, `b` and the tag bits.
- Stages 2..`NUM_STAGE`-1 carry the full `A_W+B_W`-bit signed product.
- Stage `NUM_STAGE` saturates the product to `P_W` and registers `out_p` and `out_sat`:
  - `out_p` = max(min(prod, 2^(P_W-1)-1), -2^(P_W-1)).
  - `out_sat` = 1 iff clamping changed the value.
- Without accumulate mode, every accepted beat produces exactly one result, in order.
- Accumulate mode:
  - Accumulator `acc` is `ACC_W` bits.
  - On an advancing valid beat: `acc_next = (first ? 0 : acc) + prod`, saturated to `ACC_W`. `out_sat` is sticky across the group.
  - A result is emitted only for beats with `in_last` = 1: `out_p` = saturate(`acc_next`, `P_W`), with `out_sat` = sticky OR output clamp.
  - The next beat with `in_first` clears the sticky flag.
  - `first` and `last` on the same beat form a single-beat group.
  - A beat without `first` following a `last` continues from the last sum. This is legal but discouraged.

## Timing

- Reset values: `out_valid` = 0, `out_p` = 0, `out_sat` = 0, all stage valid bits = 0, `acc` = 0, sticky = 0. `in_ready` = 1 while reset is deasserted and the pipe is empty.
- Reset asserted mid-operation discards all in-flight beats and any partial accumulation. No result is emitted for them.
- Latency without accumulate mode: a beat accepted at edge t gives `out_valid` = 1 after edge t+`NUM_STAGE-1`, i.e. `NUM_STAGE` register stages, when unstalled.
- Latency with accumulate mode: `NUM_STAGE`+1 register stages, one extra for the accumulate register.
- Throughput: one beat per cycle while `out_ready` = 1.
- Stall: `out_valid` && !`out_ready` holds `out_p`, `out_sat` and `out_valid` stable until accepted.
- Simultaneous output accept and input accept in the same cycle is allowed and is lossless.
- `in_a`, `in_b`, `in_first` and `in_last` are ignored when `in_valid` = 0.

## Configuration

- `FACE_DETECT_MAC_ACC_EN`:
  - Defined: accumulate mode is compiled in, as described above. The `acc` register and the sticky flag exist.
  - Undefined: pure pipelined multiplier. `in_first` and `in_last` are ignored, and `ACC_W` is unused. Latency is `NUM_STAGE`.

## Test plan

- Defaults, no ACC. Stream 3 beats (3,-5), (-4096,1), (100,200) with `out_ready` = 1. Expect results -15, -4096, 20000 on 3 consecutive cycles, `out_sat` = 0, with the first result `NUM_STAGE` register stages after acceptance.
- Saturation. Beat (-4096,-524288), product 2^31. Expect `out_p` = 0x7FFFFFFF, `out_sat` = 1. Beat (4095,-524288): expect -2146959360, `out_sat` = 0.
- Back-pressure. Stream 10 beats (i, i+1). Drive `out_ready` = 0 for cycles 3-7. Expect `in_ready` = 0 while the output is held, no loss or duplication, the 10 products in order, and `out_p` stable during the stall.
- ACC enabled, group of 3. Beats (2,3,first), (4,5), (-1,6,last). Expect exactly one result, 20, with `out_sat` = 0. A following single-beat group (7,7,first+last) gives 49.
- ACC enabled, sticky saturation. Group of 2 beats (-4096,-524288) each, sum 2^32. Expect `out_p` = 0x7FFFFFFF, `out_sat` = 1. The next group (1,1,first+last) gives 1 with `out_sat` = 0.
- Reset mid-stream. Accept 3 beats, then pull `reset` low for 2 cycles before any output. Expect `out_valid` = 0, `out_p` = 0 immediately (asynchronous). After release, no stale results appear, and a new beat (2,2) returns 4.

Source files
------------

// File: rtl/face_detect_mac_pipe.sv
// face_detect_mac_pipe
//   Pipelined signed multiplier with an optional group accumulator and a
//   valid/ready handshake on both sides. The whole pipe advances on one
//   enable (adv), so a stalled output holds every stage and also holds
//   in_ready low. Results are saturated to P_W bits. out_sat flags any
//   result whose value was clamped.
//
//   Optional feature macro: FACE_DETECT_MAC_ACC_EN
//     defined   : accumulate mode. Latency is NUM_STAGE+1. A result is
//                 emitted only for in_last beats.
//     undefined : plain multiplier. Latency is NUM_STAGE. in_first and
//                 in_last are ignored.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous reset, active low
//   in_valid   in   operand beat valid
//   in_ready   out  beat is accepted when in_valid && in_ready
//   in_a       in   signed operand A   [A_W]
//   in_b       in   signed operand B   [B_W]
//   in_first   in   beat opens an accumulation group
//   in_last    in   beat closes an accumulation group
//   out_valid  out  result valid
//   out_ready  in   downstream takes the result
//   out_p      out  signed saturated result [P_W]
//   out_sat    out  result (or its group) was clamped
module face_detect_mac_pipe #(
  parameter int A_W       = 13,
  parameter int B_W       = 20,
  parameter int P_W       = 32,
  parameter int NUM_STAGE = 4,
  parameter int ACC_W     = 48
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] in_a,
  input  logic [B_W-1:0] in_b,
  input  logic           in_first,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] out_p,
  output logic           out_sat
);

  localparam int M_W  = A_W + B_W;
  localparam int SW0  = (M_W > ACC_W) ? M_W : ACC_W;
  localparam int SW   = (SW0 > P_W) ? SW0 : P_W;

  // Clamp limits held at a common width so that either source (the raw
  // product or the accumulator) can be compared without truncation.
  localparam logic signed [SW-1:0] P_MAX = $signed({{(SW-P_W+1){1'b0}}, {(P_W-1){1'b1}}});
  localparam logic signed [SW-1:0] P_MIN = ~P_MAX;

  // Returns {clamped, value}.
  function automatic logic [P_W:0] sat_p(input logic signed [SW-1:0] x);
    if (x > P_MAX)
      return {1'b1, P_MAX[P_W-1:0]};
    else if (x < P_MIN)
      return {1'b1, P_MIN[P_W-1:0]};
    else
      return {1'b0, x[P_W-1:0]};
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1: operands and tags.
  logic                  s1_v, s1_first, s1_last;
  logic signed [A_W-1:0] s1_a;
  logic signed [B_W-1:0] s1_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_v     <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (adv) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_a     <= in_a;
        s1_b     <= in_b;
        s1_first <= in_first;
        s1_last  <= in_last;
      end
    end
  end

  logic signed [M_W-1:0] a_ext, b_ext, prod_c;
  assign a_ext  = M_W'(s1_a);
  assign b_ext  = M_W'(s1_b);
  assign prod_c = a_ext * b_ext;

  // Product stages 2..NUM_STAGE-1; "tail" is what the final stage consumes.
  logic signed [M_W-1:0] tail_p;
  logic                  tail_v, tail_first, tail_last;

  generate
    if (NUM_STAGE > 2) begin : g_mul
      localparam int NP = NUM_STAGE - 2;
      logic signed [M_W-1:0] p_q [NP];
      logic                  v_q [NP];
      logic                  f_q [NP];
      logic                  l_q [NP];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < NP; i++) begin
            p_q[i] <= '0;
            v_q[i] <= 1'b0;
            f_q[i] <= 1'b0;
            l_q[i] <= 1'b0;
          end
        end else if (adv) begin
          p_q[0] <= prod_c;
          v_q[0] <= s1_v;
          f_q[0] <= s1_first;
          l_q[0] <= s1_last;
          for (int i = 1; i < NP; i++) begin
            p_q[i] <= p_q[i-1];
            v_q[i] <= v_q[i-1];
            f_q[i] <= f_q[i-1];
            l_q[i] <= l_q[i-1];
          end
        end
      end

      assign tail_p     = p_q[NP-1];
      assign tail_v     = v_q[NP-1];
      assign tail_first = f_q[NP-1];
      assign tail_last  = l_q[NP-1];
    end else begin : g_mul_direct
      assign tail_p     = prod_c;
      assign tail_v     = s1_v;
      assign tail_first = s1_first;
      assign tail_last  = s1_last;
    end
  endgenerate

`ifdef FACE_DETECT_MAC_ACC_EN
  // Accumulate stage. acc_q/sticky_q only move on valid beats so bubbles
  // inside a group do not disturb the running sum.
  logic signed [ACC_W-1:0] acc_q, acc_base, acc_next;
  logic signed [ACC_W:0]   acc_sum;
  logic                    acc_ovf, sticky_q, sticky_next, emit_q;

  always_comb begin
    acc_base    = tail_first ? '0 : acc_q;
    acc_sum     = (ACC_W+1)'(acc_base) + (ACC_W+1)'(tail_p);
    acc_ovf     = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
    acc_next    = acc_sum[ACC_W-1:0];
    if (acc_ovf)
      acc_next = acc_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    sticky_next = (tail_first ? 1'b0 : sticky_q) | acc_ovf;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      sticky_q <= 1'b0;
      emit_q   <= 1'b0;
    end else if (adv) begin
      emit_q <= tail_v && tail_last;
      if (tail_v) begin
        acc_q    <= acc_next;
        sticky_q <= sticky_next;
      end
    end
  end

  // The output stage reads the accumulator before the next beat updates it
  // (same edge), so a back-to-back new group cannot corrupt the result.
  logic [P_W:0] fin;
  assign fin = sat_p(SW'(acc_q));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      out_valid <= emit_q;
      if (emit_q) begin
        out_p   <= fin[P_W-1:0];
        out_sat <= fin[P_W] | sticky_q;
      end
    end
  end
`else
  logic unused_tags;
  assign unused_tags = tail_first ^ tail_last;

  logic [P_W:0] fin;
  assign fin = sat_p(SW'(tail_p));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      out_valid <= tail_v;
      if (tail_v) begin
        out_p   <= fin[P_W-1:0];
        out_sat <= fin[P_W];
      end
    end
  end
`endif

endmodule

// File: tb/tb_face_detect_mac_pipe.sv
module tb_face_detect_mac_pipe;

  localparam int A_W       = 13;
  localparam int B_W       = 20;
  localparam int P_W       = 32;
  localparam int NUM_STAGE = 4;
  localparam int ACC_W     = 48;

  logic           clk, reset;
  logic           in_valid, in_ready, in_first, in_last;
  logic [A_W-1:0] in_a;
  logic [B_W-1:0] in_b;
  logic           out_valid, out_ready, out_sat;
  logic [P_W-1:0] out_p;

  int n_chk = 0;
  int n_err = 0;

  face_detect_mac_pipe #(
    .A_W(A_W), .B_W(B_W), .P_W(P_W), .NUM_STAGE(NUM_STAGE), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_sat(out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int     a;
    int     b;
    longint p;
    bit     s;
  } vec_t;

  vec_t vec[$];

  // Streams vec[] through the pipe. out_ready is low for cycles lo..hi
  // (lo > hi means never). gaps inserts an idle cycle with junk operands
  // between beats.
  task automatic run_stream(input int lo, input int hi, input bit gaps);
    int     n = vec.size();
    int     tx = 0, rx = 0, cyc = 0;
    int     acc_cyc[$];
    logic [P_W-1:0] held = '0;
    bit     held_v = 0;
    while (rx < n && cyc < 300) begin
      out_ready = !(cyc >= lo && cyc <= hi);
      in_valid  = (tx < n) && !(gaps && (cyc % 2 == 1));
      if (in_valid) begin
        in_a = A_W'(vec[tx].a);
        in_b = B_W'(vec[tx].b);
      end else begin
        in_a = A_W'($urandom);
        in_b = B_W'($urandom);
      end
      #1;
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", in_ready, 0);
        if (held_v) chk("stall_hold_p", out_p, held);
        held   = out_p;
        held_v = 1;
      end else begin
        held_v = 0;
      end
      if (out_valid && out_ready) begin
        chk($sformatf("res_p[%0d]", rx), $signed(out_p), vec[rx].p);
        chk($sformatf("res_sat[%0d]", rx), out_sat, vec[rx].s);
        if (lo > hi && !gaps)
          chk($sformatf("latency[%0d]", rx), cyc, acc_cyc[rx] + NUM_STAGE);
        rx++;
      end
      if (in_valid && in_ready) begin
        acc_cyc.push_back(cyc);
        tx++;
      end
      step();
      cyc++;
    end
    if (rx < n) chk("stream_timeout_results", rx, n);
    in_valid  = 0;
    out_ready = 1;
    for (int i = 0; i < NUM_STAGE + 3; i++) begin
      #1;
      chk("no_extra_result", out_valid, 0);
      step();
    end
  endtask

`ifdef FACE_DETECT_MAC_ACC_EN
  typedef struct {
    int a;
    int b;
    bit f;
    bit l;
  } beat_t;

  beat_t  bq[$];
  longint exp_p[$];
  bit     exp_s[$];

  // Drives bq[] back to back with out_ready high and compares the emitted
  // group results against exp_p/exp_s, including the accumulate latency.
  task automatic acc_seq();
    int n = bq.size();
    int tx = 0, rx = 0, cyc = 0;
    int last_cyc[$];
    out_ready = 1;
    while (cyc < n + NUM_STAGE + 8) begin
      in_valid = tx < n;
      if (in_valid) begin
        in_a     = A_W'(bq[tx].a);
        in_b     = B_W'(bq[tx].b);
        in_first = bq[tx].f;
        in_last  = bq[tx].l;
      end
      #1;
      if (out_valid) begin
        if (rx < exp_p.size()) begin
          chk($sformatf("acc_p[%0d]", rx), $signed(out_p), exp_p[rx]);
          chk($sformatf("acc_sat[%0d]", rx), out_sat, exp_s[rx]);
          chk($sformatf("acc_latency[%0d]", rx), cyc, last_cyc[rx] + NUM_STAGE + 1);
        end
        rx++;
      end
      if (in_valid && in_ready) begin
        if (bq[tx].l) last_cyc.push_back(cyc);
        tx++;
      end
      step();
      cyc++;
    end
    chk("acc_result_count", rx, exp_p.size());
    in_valid = 0;
    in_first = 0;
    in_last  = 0;
    bq.delete();
    exp_p.delete();
    exp_s.delete();
  endtask
`endif

  initial begin
    int got;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_p", out_p, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();

`ifndef FACE_DETECT_MAC_ACC_EN
    // Basic stream, latency and ordering.
    vec.push_back('{3, -5, -15, 0});
    vec.push_back('{-4096, 1, -4096, 0});
    vec.push_back('{100, 200, 20000, 0});
    run_stream(1, 0, 0);

    // Saturation boundaries, with idle gaps and junk operands in between.
    vec.delete();
    vec.push_back('{-4096, -524288, 64'sd2147483647, 1});
    vec.push_back('{4095, -524288, -64'sd2146959360, 0});
    vec.push_back('{4095, 524287, 64'sd2146955265, 0});
    vec.push_back('{-4096, 524287, -64'sd2147479552, 0});
    vec.push_back('{0, -524288, 0, 0});
    vec.push_back('{-1, -1, 1, 0});
    run_stream(1, 0, 1);

    // Back-pressure: out_ready low for cycles 3..7.
    vec.delete();
    for (int i = 0; i < 10; i++) vec.push_back('{i, i + 1, longint'(i * (i + 1)), 0});
    run_stream(3, 7, 0);
`else
    bq.push_back('{2, 3, 1, 0});
    bq.push_back('{4, 5, 0, 0});
    bq.push_back('{-1, 6, 0, 1});
    bq.push_back('{7, 7, 1, 1});
    exp_p.push_back(20);  exp_s.push_back(0);
    exp_p.push_back(49);  exp_s.push_back(0);
    acc_seq();

    bq.push_back('{-4096, -524288, 1, 0});
    bq.push_back('{-4096, -524288, 0, 1});
    bq.push_back('{1, 1, 1, 1});
    exp_p.push_back(64'sd2147483647); exp_s.push_back(1);
    exp_p.push_back(1);               exp_s.push_back(0);
    acc_seq();
`endif

    // Reset mid-stream: three beats in flight, none may come out.
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      in_a     = A_W'(5 + i);
      in_b     = B_W'(5);
      in_first = 1;
      in_last  = 1;
      step();
    end
    in_valid = 0;
    reset    = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_p", out_p, 0);
    chk("midrst_out_sat", out_sat, 0);
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < NUM_STAGE + 4; i++) begin
      #1;
      chk("midrst_no_stale", out_valid, 0);
      step();
    end

    in_valid = 1;
    in_a     = A_W'(2);
    in_b     = B_W'(2);
    in_first = 1;
    in_last  = 1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    step();
    in_valid = 0;
    got      = 0;
    for (int i = 0; i < NUM_STAGE + 6 && got == 0; i++) begin
      #1;
      if (out_valid) begin
        got = 1;
        chk("post_rst_p", $signed(out_p), 4);
        chk("post_rst_sat", out_sat, 0);
      end
      step();
    end
    if (got == 0) chk("post_rst_timeout", got, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
